// File: rtl/node_sched_rr_pkg.sv
// Package shared by the round-robin node scheduler.
// Contents:
//   - default parameter values (requester count, data width, watchdog limits)
//   - scheduler FSM state encoding
//   - idx_width(): width of a requester index, at least one bit
package node_sched_rr_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_W         = 16;
  localparam int DEF_LAUNCH_TO = 8;
  localparam int DEF_RUN_TO    = 65535;

  // ST_ABORT is only ever occupied for one cycle, on the way back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_RDY  = 3'd3,
    ST_RETIRE    = 3'd4,
    ST_ABORT     = 3'd5
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/node_sched_rr_if.sv
// Interface bundling the requester side and the node side of the scheduler.
//   req      level request per requester
//   in0_bus  operand 0, requester i at [i*W +: W]
//   in1_bus  operand 1 (iteration count), same packing
//   gnt      one-hot owner of the node for the whole job
//   done     one-cycle pulse, res valid for that requester
//   err      one-cycle pulse, job aborted by the watchdog
//   res      result of the last completed job
//   busy     scheduler not idle
//   node_st  start level to the node
//   node_in0 latched operand 0 to the node
//   node_in1 latched operand 1 to the node
//   node_rd  node ready (1 = idle / result valid)
//   node_res node result
// Modports: slave = the scheduler, master = whatever drives requests and
// models the node.
interface node_sched_rr_if
  import node_sched_rr_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
) ();

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] in0_bus;
  logic [N_REQ*W-1:0] in1_bus;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic [W-1:0]       res;
  logic               busy;
  logic               node_st;
  logic [W-1:0]       node_in0;
  logic [W-1:0]       node_in1;
  logic               node_rd;
  logic [W-1:0]       node_res;

  modport slave (
    input  req, in0_bus, in1_bus, node_rd, node_res,
    output gnt, done, err, res, busy, node_st, node_in0, node_in1
  );

  modport master (
    output req, in0_bus, in1_bus, node_rd, node_res,
    input  gnt, done, err, res, busy, node_st, node_in0, node_in1
  );

endinterface

// File: rtl/node_sched_rr_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index ptr and wrapping, and returns the first
// requester found.
//   req       request vector
//   ptr       highest-priority index for this pick
//   pick_oh   one-hot of the chosen requester (all zero when none)
//   pick_idx  index of the chosen requester (zero when none)
//   any       at least one request present
module rr_pick
  import node_sched_rr_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable driven here gets a default before the loop, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any           = 1'b1;
        pick_idx      = cand;
        pick_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_sched_rr.sv
// Round-robin scheduler that shares one recursion node (ST/RD/RES/IN0/IN1
// handshake) among N_REQ requesters.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; a job in flight is dropped silently
//   bus    node_sched_rr_if.slave (requests, operands, grant/done/err,
//          result, busy flag, node start/operands/ready/result)
// Job sequence: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_RDY -> RETIRE -> IDLE.
// A watchdog that expires diverts the job through ABORT instead of RETIRE.
//   - IDLE grants only when the node reports ready. It latches the winner's
//     operands and raises node_st on that same edge.
//   - LAUNCH holds node_st high until node_rd falls. If LAUNCH_TO cycles pass
//     without the fall, the job aborts.
//   - WAIT_BUSY is a single settling cycle that clears the watchdog.
//   - WAIT_RDY waits for node_rd to rise. If RUN_TO cycles pass without the
//     rise, the job aborts.
//   - RETIRE and ABORT each pulse done or err for one cycle, drop gnt and move
//     the pointer one past the served requester.
// Latency from a seen request to node_st high is one cycle. Latency from the
// node_rd rise to done is two cycles.
module node_sched_rr
  import node_sched_rr_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int W         = DEF_W,
  parameter int LAUNCH_TO = DEF_LAUNCH_TO,
  parameter int RUN_TO    = DEF_RUN_TO
) (
  input logic            clk,
  input logic            rst_n,
  node_sched_rr_if.slave bus
);

  localparam int IDX_W = idx_width(N_REQ);
  // Both watchdogs share one counter. The counter starts at zero, so the
  // last allowed value is the limit minus one.
  localparam logic [W-1:0] LAUNCH_LAST = W'(LAUNCH_TO - 1);
  localparam logic [W-1:0] RUN_LAST    = W'(RUN_TO - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [W-1:0]     wdog;
  logic             rd_q;
  logic             rd_fall;
  logic             rd_rise;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .pick_oh (pick_oh),
    .pick_idx(pick_idx),
    .any     (pick_any)
  );

  // Edges are judged against the value registered on the previous cycle.
  // The node's RD line is assumed to be synchronous to clk.
  assign rd_fall = rd_q & ~bus.node_rd;
  assign rd_rise = ~rd_q & bus.node_rd;

  assign ptr_next = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  // NOTE: all state in this block is assigned with non-blocking (<=) so
  // every register samples the pre-edge value of every other one, which is
  // what the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      gnt_idx      <= '0;
      wdog         <= '0;
      rd_q         <= 1'b1;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.err      <= '0;
      bus.res      <= '0;
      bus.busy     <= 1'b0;
      bus.node_st  <= 1'b0;
      bus.node_in0 <= '0;
      bus.node_in1 <= '0;
    end else begin
      rd_q     <= bus.node_rd;
      // done/err are pulses: cleared every cycle unless retiring below.
      bus.done <= '0;
      bus.err  <= '0;

      case (state)
        ST_IDLE: begin
          // The node must be idle before it is started. node_st is low
          // throughout IDLE, so the node's starter re-arms between jobs.
          if (pick_any && bus.node_rd) begin
            state        <= ST_LAUNCH;
            bus.gnt      <= pick_oh;
            gnt_idx      <= pick_idx;
            bus.node_in0 <= bus.in0_bus[int'(pick_idx) * W +: W];
            bus.node_in1 <= bus.in1_bus[int'(pick_idx) * W +: W];
            bus.node_st  <= 1'b1;
            bus.busy     <= 1'b1;
            wdog         <= '0;
          end
        end

        ST_LAUNCH: begin
          // The node's starter is level-sensitive, so node_st stays high
          // until the node acknowledges by dropping RD.
          if (rd_fall) begin
            bus.node_st <= 1'b0;
            state       <= ST_WAIT_BUSY;
          end else if (wdog == LAUNCH_LAST) begin
            bus.node_st <= 1'b0;
            state       <= ST_ABORT;
          end else begin
            wdog <= wdog + W'(1);
          end
        end

        ST_WAIT_BUSY: begin
          wdog  <= '0;
          state <= ST_WAIT_RDY;
        end

        ST_WAIT_RDY: begin
          // If the rise lands on the final watchdog cycle, the rise wins.
          if (rd_rise) begin
            bus.res <= bus.node_res;
            state   <= ST_RETIRE;
          end else if (wdog == RUN_LAST) begin
            state <= ST_ABORT;
          end else begin
            wdog <= wdog + W'(1);
          end
        end

        ST_RETIRE, ST_ABORT: begin
          // gnt is one-hot, so copying it yields a one-hot done/err pulse.
          // An aborted job leaves res untouched.
          if (state == ST_ABORT) begin
            bus.err <= bus.gnt;
          end else begin
            bus.done <= bus.gnt;
          end
          bus.gnt     <= '0;
          bus.node_st <= 1'b0;
          bus.busy    <= 1'b0;
          ptr         <= ptr_next;
          state       <= ST_IDLE;
        end

        default: begin
          bus.gnt     <= '0;
          bus.node_st <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_sched_rr.sv
// Self-checking bench for node_sched_rr.
// A stub node on the falling edge models the node's RD/RES behaviour, with a
// programmable busy time and two fault modes. The stub never raises RD,
// or never drops it.
// Stimulus pushes the expected done/err events into a scoreboard. A monitor
// pops one entry per event and checks kind, owner, result and the cycle
// count since the grant.
module tb_node_sched_rr;
  import node_sched_rr_pkg::*;

  localparam int N         = 4;
  localparam int W         = 16;
  localparam int LAUNCH_TO = 8;
  localparam int RUN_TO    = 20;

  typedef struct {
    bit           is_err;
    logic [N-1:0] who;
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  typedef enum {M_NORMAL, M_NO_FALL, M_NO_RISE} smode_t;
  typedef enum {P_IDLE, P_BUSY} sphase_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_events = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [N-1:0] prev_gnt = '0;

  smode_t       stub_mode = M_NORMAL;
  sphase_t      sphase = P_IDLE;
  int           busy_dly = 3;
  int           k = 0;
  logic [W-1:0] sa = '0;
  logic [W-1:0] sbv = '0;

  node_sched_rr_if #(.N_REQ(N), .W(W)) bus ();

  node_sched_rr #(
    .N_REQ    (N),
    .W        (W),
    .LAUNCH_TO(LAUNCH_TO),
    .RUN_TO   (RUN_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_err, input int who, input int res, input int lat);
    exp_t e;
    e.is_err = is_err;
    e.who    = N'(1) << who;
    e.res    = W'(res);
    e.lat    = lat;
    sb.push_back(e);
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    bus.in0_bus[i*W +: W] = W'(a);
    bus.in1_bus[i*W +: W] = W'(b);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},      32'(bus.gnt), 0);
    check({tag, "_done"},     32'(bus.done), 0);
    check({tag, "_err"},      32'(bus.err), 0);
    check({tag, "_res"},      32'(bus.res), 0);
    check({tag, "_busy"},     32'(bus.busy), 0);
    check({tag, "_node_st"},  32'(bus.node_st), 0);
    check({tag, "_node_in0"}, 32'(bus.node_in0), 0);
    check({tag, "_node_in1"}, 32'(bus.node_in1), 0);
  endtask

  // Asserts reset mid-cycle, checks that the outputs cleared at once, then
  // releases reset on a falling edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_events(input int target, input int budget, input string what);
    int n = 0;
    while (n_events < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(what, n_events, target);
  endtask

  task automatic wait_grant(input int budget, input string what);
    int n = 0;
    while (bus.gnt == '0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(what, 32'(bus.gnt != '0), 1);
  endtask

  // Stub node: drops RD on the first falling edge that sees node_st, then
  // raises RD with result a*b+7 once busy_dly more falling edges have passed.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.node_rd  = 1'b1;
      bus.node_res = '0;
      sphase       = P_IDLE;
      k            = 0;
    end else begin
      case (sphase)
        P_IDLE: begin
          if (bus.node_st && stub_mode != M_NO_FALL) begin
            bus.node_rd = 1'b0;
            sa          = bus.node_in0;
            sbv         = bus.node_in1;
            k           = busy_dly;
            sphase      = P_BUSY;
          end
        end
        P_BUSY: begin
          if (stub_mode != M_NO_RISE) begin
            if (k == 0) begin
              bus.node_res = W'(sa * sbv + W'(7));
              bus.node_rd  = 1'b1;
              sphase       = P_IDLE;
            end else begin
              k--;
            end
          end
        end
        default: sphase = P_IDLE;
      endcase
    end
  end

  // Monitor: checks every done/err pulse against the scoreboard, and every
  // new grant for one-hot ownership with start and busy high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done != '0 || bus.err != '0) begin
        n_events++;
        if (sb.size() == 0) begin
          check("unexpected_event", 32'(bus.done | bus.err), 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind",    32'(bus.err != '0), 32'(mon_e.is_err));
          check("event_who",     32'(bus.done | bus.err), 32'(mon_e.who));
          check("done_err_excl", 32'((bus.done != '0) && (bus.err != '0)), 0);
          check("res",           32'(bus.res), 32'(mon_e.res));
          check("latency",       cyc - gnt_cyc, mon_e.lat);
          check("gnt_clear",     32'(bus.gnt), 0);
          check("st_low",        32'(bus.node_st), 0);
        end
      end
      if (bus.gnt != '0 && prev_gnt == '0) begin
        gnt_cyc = cyc;
        check("gnt_onehot",    $countones(bus.gnt), 1);
        check("st_on_grant",   32'(bus.node_st), 1);
        check("busy_on_grant", 32'(bus.busy), 1);
      end
      prev_gnt = bus.gnt;
    end else begin
      prev_gnt = '0;
    end
  end

  initial begin
    bus.req     = '0;
    bus.in0_bus = '0;
    bus.in1_bus = '0;
    apply_reset("reset0");

    // 1: single requester 0, 5*3+7 = 22. Stub busy for 3 edges, so done
    //    arrives 6 cycles after the grant.
    set_lane(0, 5, 3);
    push(0, 0, 22, 6);
    bus.req = 4'b0001;
    wait_events(1, 40, "t1_done");
    bus.req = '0;

    // 2: all four requesting from pointer 0, giving order 0,1,2,3,0.
    //    Lane i operands are (100+i, 2), so the result is 207+2i.
    apply_reset("reset2");
    for (int i = 0; i < N; i++) set_lane(i, 100 + i, 2);
    push(0, 0, 207, 6);
    push(0, 1, 209, 6);
    push(0, 2, 211, 6);
    push(0, 3, 213, 6);
    push(0, 0, 207, 6);
    bus.req = 4'b1111;
    wait_events(6, 120, "t2_five_jobs");
    bus.req = '0;

    // 3: pointer at 1, and the node never drops RD. err[1] arrives
    //    LAUNCH_TO+1 = 9 cycles after the grant, with res held at 207.
    //    Requester 2 is served next.
    push(1, 1, 207, LAUNCH_TO + 1);
    push(0, 2, 211, 6);
    stub_mode = M_NO_FALL;
    bus.req   = 4'b0110;
    wait_events(7, 40, "t3_abort");
    stub_mode = M_NORMAL;
    bus.req   = 4'b0100;
    wait_events(8, 40, "t3_next");
    bus.req = '0;

    // 4: pointer at 3; the node drops RD but never raises it. That is one
    //    LAUNCH cycle, one settle cycle, RUN_TO cycles waiting, then ABORT,
    //    so err arrives RUN_TO+3 = 23 cycles after the grant, res held at 211.
    push(1, 3, 211, RUN_TO + 3);
    stub_mode = M_NO_RISE;
    bus.req   = 4'b1000;
    wait_events(9, 60, "t4_run_abort");
    bus.req = '0;

    // 5: reset while in WAIT_RDY clears everything asynchronously. After
    //    release, a fresh request from 0 is served from pointer 0.
    apply_reset("reset5a");
    stub_mode = M_NORMAL;
    busy_dly  = 10;
    bus.req   = 4'b0001;
    wait_grant(10, "t5_grant");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset5b");
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    busy_dly = 3;
    push(0, 0, 207, 6);
    bus.req = 4'b0101;
    wait_events(10, 40, "t5_fresh");
    bus.req = '0;

    // 6: pointer at 1, so requester 2 wins. It drops its request and its
    //    lane is overwritten after the grant. The latched 10*4+7 = 47 result
    //    is still expected.
    set_lane(2, 10, 4);
    push(0, 2, 47, 6);
    bus.req = 4'b0100;
    wait_grant(10, "t6_grant");
    bus.req = '0;
    set_lane(2, 999, 999);
    wait_events(11, 40, "t6_done");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d events expected 11", n_events);
    $fatal(1, "bench time limit");
  end

endmodule
